// File: rtl/fifo_ctrl_e1_pkg.sv
// fifo_ctrl_e1_pkg: default geometry and thresholds shared by the FIFO control slice
package fifo_ctrl_e1_pkg;
    localparam int DEF_DATA_SIZE  = 10;
    localparam int DEF_QUEUE_SIZE = 8;
    localparam int DEF_AFULL_TH   = 250;
    localparam int DEF_AEMPTY_TH  = 4;
endpackage

// File: rtl/fifo_ctrl_e1_if.sv
// fifo_ctrl_e1_if: producer/consumer requests, RAM address/enable/data and status of the FIFO control stage
interface fifo_ctrl_e1_if
    import fifo_ctrl_e1_pkg::*;
#(
    parameter int DATA_SIZE       = DEF_DATA_SIZE,
    parameter int MAIN_QUEUE_SIZE = DEF_QUEUE_SIZE
);
    logic                       push;
    logic                       pop;
    logic [DATA_SIZE-1:0]       data_in;
    logic [DATA_SIZE-1:0]       ram_data;
    logic                       write;
    logic                       read;
    logic [MAIN_QUEUE_SIZE-1:0] wr_ptr;
    logic [MAIN_QUEUE_SIZE-1:0] rd_ptr;
    logic [DATA_SIZE-1:0]       data_out;
    logic                       valid_out;
    logic [MAIN_QUEUE_SIZE:0]   fifo_count;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output push, pop, data_in,
        input  data_out, valid_out, fifo_count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
    modport slave (
        input  push, pop, ram_data,
        output write, read, wr_ptr, rd_ptr, data_out, valid_out, fifo_count,
               full, empty, almost_full, almost_empty, overflow, underflow
    );
    // data_in bypasses the controller and lands straight on the RAM write port
    modport ram (
        input  write, wr_ptr, data_in, rd_ptr,
        output ram_data
    );
endinterface

// File: rtl/fifo_flags_e1.sv
// fifo_flags_e1: combinational status decode of an occupancy count, reusable for any queue depth
module fifo_flags_e1
    import fifo_ctrl_e1_pkg::*;
#(
    parameter int MAIN_QUEUE_SIZE = DEF_QUEUE_SIZE,
    parameter int AFULL_TH        = DEF_AFULL_TH,
    parameter int AEMPTY_TH       = DEF_AEMPTY_TH
)(
    input  logic [MAIN_QUEUE_SIZE:0] i_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty
);
    localparam int                   DEPTH  = 2**MAIN_QUEUE_SIZE;
    localparam logic [MAIN_QUEUE_SIZE:0] W_DEPTH = DEPTH[MAIN_QUEUE_SIZE:0];
    localparam logic [MAIN_QUEUE_SIZE:0] W_AF    = AFULL_TH[MAIN_QUEUE_SIZE:0];
    localparam logic [MAIN_QUEUE_SIZE:0] W_AE    = AEMPTY_TH[MAIN_QUEUE_SIZE:0];

    assign o_full         = i_count == W_DEPTH;
    assign o_empty        = i_count == '0;
    assign o_almost_full  = i_count >= W_AF;
    assign o_almost_empty = i_count <= W_AE;
endmodule

// File: rtl/fifo_ctrl_e1.sv
// fifo_ctrl_e1: FIFO control stage; accepts push/pop, drives RAM pointers/enables,
// tracks occupancy with sticky error flags and registers read data one cycle after pop.
module fifo_ctrl_e1
    import fifo_ctrl_e1_pkg::*;
#(
    parameter int DATA_SIZE       = DEF_DATA_SIZE,
    parameter int MAIN_QUEUE_SIZE = DEF_QUEUE_SIZE,
    parameter int AFULL_TH        = DEF_AFULL_TH,
    parameter int AEMPTY_TH       = DEF_AEMPTY_TH
)(
    input logic           clk,
    input logic           reset_L,
    fifo_ctrl_e1_if.slave bus
);
    localparam int QW = MAIN_QUEUE_SIZE;
    localparam int CW = MAIN_QUEUE_SIZE + 1;

    logic [QW-1:0]        r_wr_ptr;
    logic [QW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [DATA_SIZE-1:0] r_data_out;
    logic                 r_valid;
    logic                 r_overflow;
    logic                 r_underflow;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    fifo_flags_e1 #(
        .MAIN_QUEUE_SIZE(MAIN_QUEUE_SIZE),
        .AFULL_TH       (AFULL_TH),
        .AEMPTY_TH      (AEMPTY_TH)
    ) u_flags (
        .i_count       (r_count),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_almost_full (bus.almost_full),
        .o_almost_empty(bus.almost_empty)
    );

    // A pop frees the slot being written, so a full queue still accepts a paired push
    assign w_pop_ok  = reset_L && bus.pop && !w_empty;
    assign w_push_ok = reset_L && bus.push && (!w_full || w_pop_ok);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + QW'(1);
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + QW'(1);
            if (w_pop_ok) r_data_out <= bus.ram_data;
            r_valid     <= w_pop_ok;
            r_count     <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            r_overflow  <= r_overflow | (bus.push & ~w_push_ok);
            r_underflow <= r_underflow | (bus.pop & ~w_pop_ok);
        end
    end

    assign bus.write      = w_push_ok;
    assign bus.read       = w_pop_ok;
    assign bus.wr_ptr     = r_wr_ptr;
    assign bus.rd_ptr     = r_rd_ptr;
    assign bus.data_out   = r_data_out;
    assign bus.valid_out  = r_valid;
    assign bus.fifo_count = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;
endmodule

// File: doc/fifo_ctrl_e1.md
Name: fifo_ctrl_e1

Overview:
- Control stage for a main FIFO queue.
- Accepts push/pop requests and generates write/read enables and wr_ptr/rd_ptr for the FIFO RAM.
- Tracks occupancy and raises full/empty, almost_full/almost_empty, and sticky overflow/underflow flags.
- Registers the RAM read data into a one-cycle-latency output with a valid strobe; sits directly upstream of the RAM address and enable inputs and downstream of its data output.

Parameters:
- DATA_SIZE, 10, data word width; matches RAM data width.
- MAIN_QUEUE_SIZE, 8, pointer width; FIFO depth DEPTH = 2**MAIN_QUEUE_SIZE.
- AFULL_TH, 250, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset_L  in  1  asynchronous, active-low reset.
- push  in  1  producer request to enqueue data_in.
- pop  in  1  consumer request to dequeue.
- data_in  in  DATA_SIZE  producer word; passed through unchanged to the RAM data input.
- ram_data  in  DATA_SIZE  combinational RAM read data at rd_ptr.
- write  out  1  RAM write enable (combinational).
- read  out  1  RAM read enable (combinational).
- wr_ptr  out  MAIN_QUEUE_SIZE  RAM write address (registered).
- rd_ptr  out  MAIN_QUEUE_SIZE  RAM read address (registered).
- data_out  out  DATA_SIZE  registered dequeued word.
- valid_out  out  1  data_out holds a word popped on the previous cycle.
- fifo_count  out  MAIN_QUEUE_SIZE+1  occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status, decoded from fifo_count (combinational).
- overflow, underflow  out  1 each  sticky error flags.

Behaviour:
- Async reset (reset_L=0), effective immediately, including mid-operation:
  - wr_ptr=0, rd_ptr=0, fifo_count=0, data_out=0, valid_out=0, overflow=0, underflow=0.
  - Resulting status: empty=1, almost_empty=1, full=0, almost_full=0.
  - RAM contents are not cleared.
- Accept rules:
  - push_ok = push && (!full || pop_ok).
  - pop_ok = pop && !empty.
  - write = push_ok; read = pop_ok. Both are 0 while reset_L=0.
- On posedge with push_ok: wr_ptr <= wr_ptr+1, modulo DEPTH, natural wrap.
- On posedge with pop_ok: rd_ptr <= rd_ptr+1 (wrapping); data_out <= ram_data; valid_out <= 1.
- On posedge without pop_ok: valid_out <= 0; data_out holds.
- Pop latency: pop asserted in cycle N gives the word on data_out with valid_out=1 in cycle N+1. The RAM is show-ahead, so ram_data is the head word before the edge.
- fifo_count update:
  - +1 if push_ok only.
  - -1 if pop_ok only.
  - Unchanged if both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Status decode: full = (fifo_count==DEPTH); empty = (fifo_count==0).
- Simultaneous push+pop:
  - When full: both accepted; the write lands in the slot being read, the old word is read (RAM write is nonblocking); count stays DEPTH.
  - When empty: push accepted, pop rejected, underflow set; count becomes 1.
- Push while full without pop: dropped, no pointer or count change; overflow <= 1, held until reset.
- Pop while empty: ignored; underflow <= 1, held until reset; valid_out=0 next cycle.
- Pointer equality is ambiguous (full or empty); it is always disambiguated by fifo_count, never by pointer comparison.

Decomposition:
- No shared package required.
- localparam DEPTH = 2**MAIN_QUEUE_SIZE is local to the module.
- Natural sub-module: fifo_flags_e1, combinational, takes fifo_count and generates full/empty/almost_full/almost_empty from the parameters; reusable for other queues.
- The RAM is instantiated by the parent, not inside this block.

Test Plan (MAIN_QUEUE_SIZE=2, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1, with a behavioural RAM attached):
- Reset then idle:
  - fifo_count=0, empty=1, almost_empty=1, full=0, valid_out=0, wr_ptr=rd_ptr=0.
- Push 0x101,0x102,0x103,0x104 on consecutive cycles:
  - Count steps 1,2,3,4; almost_full at count 3; full=1 after the fourth push; wr_ptr wraps to 0.
- From full, pop 4 times:
  - data_out = 0x101..0x104, each one cycle after its pop, valid_out=1 each cycle.
  - empty=1 after the last pop; rd_ptr wraps to 0.
- Full, push 0x1FF without pop:
  - overflow=1 and stays 1; count stays 4.
  - Subsequent pops return the original 4 words, with no 0x1FF.
- Full, simultaneous push 0x055 + pop for one cycle:
  - data_out = oldest word, count stays 4.
  - 0x055 is returned as the 4th word of the next drain.
- Empty, simultaneous push 0x0AA + pop:
  - underflow=1, valid_out=0 next cycle, count=1.
  - Next pop yields 0x0AA.
- Assert reset_L=0 mid-stream at count=2 (asynchronously, between edges):
  - All outputs return to reset values immediately, before the next clk edge; flags clear.
